// File: rtl/decode_scoreboard_pkg.sv
// Shared constants for the decode-stage register file and scoreboard:
// immediate/jump field widths and the immediate extension select encoding.
package decode_scoreboard_pkg;

    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;
    localparam int PCHI_W  = 4;
    localparam int JUMP_W  = PCHI_W + JADDR_W + 2;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_sel_e;

endpackage

// File: rtl/decode_busy_table.sv
// Per-register busy bits: set by issue, cleared by a committed write.
// Set wins over clear, and register 0 is never busy.
module decode_busy_table #(
    parameter int NREGS = 32
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic [NREGS-1:0] i_set,
    input  logic [NREGS-1:0] i_clr,
    output logic [NREGS-1:0] o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_next;

    always_comb begin
        w_next    = (r_busy & ~i_clr) | i_set;
        w_next[0] = 1'b0;
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_next;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/decode_scoreboard.sv
// Multi-lane decode stage: bypassed register file reads, busy scoreboard with
// stall detection, immediate extension and jump target formation.
module decode_scoreboard
    import decode_scoreboard_pkg::*;
#(
    parameter  int NLANES = 2,
    parameter  int DW     = 32,
    parameter  int NREGS  = 32,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                      reloj,
    input  logic                      reset,
    input  logic [NLANES*AW-1:0]      DIR_A,
    input  logic [NLANES*AW-1:0]      DIR_B,
    input  logic [NLANES*AW-1:0]      DIR_WRA,
    input  logic [NLANES*AW-1:0]      DIR_DST,
    input  logic [NLANES*DW-1:0]      DI,
    input  logic [NLANES-1:0]         REG_RD,
    input  logic [NLANES-1:0]         REG_WR,
    input  logic [NLANES-1:0]         ISSUE,
    input  logic [NLANES-1:0]         SEL_I,
    input  logic [NLANES*IMM_W-1:0]   IMD,
    input  logic [NLANES*JADDR_W-1:0] address,
    input  logic [NLANES*PCHI_W-1:0]  pc_hi,
    output logic [NLANES*DW-1:0]      DOA,
    output logic [NLANES*DW-1:0]      DOB,
    output logic [NLANES*DW-1:0]      out_mux_sz,
    output logic [NLANES*DW-1:0]      out_addr,
    output logic [NLANES-1:0]         STALL,
    output logic [NREGS-1:0]          BUSY
);

    logic [DW-1:0]    r_regs [NREGS];
    logic [AW-1:0]    w_wrAddr [NLANES];
    logic [NLANES-1:0] w_wrEn;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;

    // A write to register 0 is not a write at all: no commit, no bypass, no clear.
    for (genvar l = 0; l < NLANES; l++) begin : g_wr
        assign w_wrAddr[l] = DIR_WRA[l*AW +: AW];
        assign w_wrEn[l]   = !REG_WR[l] && (w_wrAddr[l] != '0);
    end

    // Ascending lane order makes the highest-index writer the last assignment.
    always_ff @(posedge reloj) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int l = 0; l < NLANES; l++) begin
                if (w_wrEn[l]) begin
                    r_regs[w_wrAddr[l]] <= DI[l*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int l = 0; l < NLANES; l++) begin
            if (ISSUE[l]) begin
                w_set[DIR_DST[l*AW +: AW]] = 1'b1;
            end
            if (w_wrEn[l]) begin
                w_clr[w_wrAddr[l]] = 1'b1;
            end
        end
    end

    decode_busy_table #(
        .NREGS (NREGS)
    ) u_busy (
        .reloj  (reloj),
        .reset  (reset),
        .i_set  (w_set),
        .i_clr  (w_clr),
        .o_busy (BUSY)
    );

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        logic [AW-1:0] w_srcA;
        logic [AW-1:0] w_srcB;
        logic [DW-1:0] w_dataA;
        logic [DW-1:0] w_dataB;
        logic          w_hitA;
        logic          w_hitB;
        logic          w_intraA;
        logic          w_intraB;
        logic [DW-1:0] w_ext;
        logic [DW-1:0] w_jump;

        assign w_srcA = DIR_A[g*AW +: AW];
        assign w_srcB = DIR_B[g*AW +: AW];

        // Write-first bypass; a later (higher) lane overrides an earlier match.
        always_comb begin
            w_dataA  = r_regs[w_srcA];
            w_dataB  = r_regs[w_srcB];
            w_hitA   = 1'b0;
            w_hitB   = 1'b0;
            w_intraA = 1'b0;
            w_intraB = 1'b0;
            for (int l = 0; l < NLANES; l++) begin
                if (w_wrEn[l] && (w_wrAddr[l] == w_srcA)) begin
                    w_dataA = DI[l*DW +: DW];
                    w_hitA  = 1'b1;
                end
                if (w_wrEn[l] && (w_wrAddr[l] == w_srcB)) begin
                    w_dataB = DI[l*DW +: DW];
                    w_hitB  = 1'b1;
                end
                if ((l < g) && ISSUE[l] && (DIR_DST[l*AW +: AW] == w_srcA) && (w_srcA != '0)) begin
                    w_intraA = 1'b1;
                end
                if ((l < g) && ISSUE[l] && (DIR_DST[l*AW +: AW] == w_srcB) && (w_srcB != '0)) begin
                    w_intraB = 1'b1;
                end
            end
        end

        assign DOA[g*DW +: DW] = (REG_RD[g] || (w_srcA == '0)) ? '0 : w_dataA;
        assign DOB[g*DW +: DW] = (REG_RD[g] || (w_srcB == '0)) ? '0 : w_dataB;

        assign STALL[g] = !REG_RD[g] &&
                          ((BUSY[w_srcA] && !w_hitA) || (BUSY[w_srcB] && !w_hitB) ||
                           w_intraA || w_intraB);

        always_comb begin
            w_ext = (ext_sel_e'(SEL_I[g]) == EXT_SIGN) ? {DW{IMD[g*IMM_W + IMM_W - 1]}} : '0;
            w_ext[IMM_W-1:0] = IMD[g*IMM_W +: IMM_W];
        end

        always_comb begin
            w_jump = '0;
            w_jump[JUMP_W-1:0] = {pc_hi[g*PCHI_W +: PCHI_W], address[g*JADDR_W +: JADDR_W], 2'b00};
        end

        assign out_mux_sz[g*DW +: DW] = w_ext;
        assign out_addr[g*DW +: DW]   = w_jump;
    end

endmodule
